// File: rtl/la_pkg.sv
// la_pkg: state encoding, widths and trigger-match helper shared by la_capture_core.
package la_pkg;
  localparam int LA_STATE_W = 3;
  localparam int LA_MAX_W = 512;
  typedef enum logic [LA_STATE_W-1:0] {
    LA_IDLE = 3'd0,
    LA_PRE  = 3'd1,
    LA_WAIT = 3'd2,
    LA_POST = 3'd3,
    LA_DONE = 3'd4
  } la_state_e;
  // Operands are zero-extended to LA_MAX_W so one function serves any probe width up to that size.
  function automatic logic la_match(input logic [LA_MAX_W-1:0] probe, input logic [LA_MAX_W-1:0] mask,
                                    input logic [LA_MAX_W-1:0] value);
    return ((probe ^ value) & mask) == '0;
  endfunction
endpackage

// File: rtl/la_sample_ram.sv
// la_sample_ram: simple dual-port sample buffer, DEPTH x PROBE_W, with a registered read port.
// Ports: clk, resetn (async active-low, clears the read register only), we_i/wr_addr_i/wr_data_i write port,
// rd_addr_i/rd_data_o read port with 1-cycle latency.
module la_sample_ram #(
  parameter int PROBE_W = 37,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [PROBE_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [PROBE_W-1:0] rd_data_o
);
  logic [PROBE_W-1:0] mem [DEPTH];
  logic [PROBE_W-1:0] rd_data_d, rd_data_q;
  always_comb rd_data_d = mem[rd_addr_i];
  always_ff @(posedge clk) begin
    if (we_i) mem[wr_addr_i] <= wr_data_i;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_data_q <= '0;
    else rd_data_q <= rd_data_d;
  end
  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyser capture engine with pre-trigger history, mask/value trigger and random-access readout.
// Ports: clk, resetn (async active-low); probe_i sampled each cycle; arm_i/abort_i control pulses;
// trig_mask_i/trig_value_i trigger setup; pretrig_i pre-trigger depth; rd_addr_i/rd_data_o readout (0 = oldest, 1-cycle latency);
// state_o FSM state, done_o capture complete, trig_addr_o physical address of the trigger sample.
// Optional macro LA_EDGE_TRIG_EN adds trig_edge_i for per-bit rising-into-value edge triggering.
module la_capture_core import la_pkg::*; #(
  parameter int PROBE_W = 37,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [PROBE_W-1:0]    probe_i,
  input  logic                  arm_i,
  input  logic                  abort_i,
  input  logic [PROBE_W-1:0]    trig_mask_i,
  input  logic [PROBE_W-1:0]    trig_value_i,
`ifdef LA_EDGE_TRIG_EN
  input  logic [PROBE_W-1:0]    trig_edge_i,
`endif
  input  logic [ADDR_W-1:0]     pretrig_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [PROBE_W-1:0]    rd_data_o,
  output logic [LA_STATE_W-1:0] state_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     trig_addr_o
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  la_state_e state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d, cnt_inc, post_len;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d, wr_ptr_q, wr_ptr_d, trig_addr_q, trig_addr_d, rd_phys;
  logic done_q, done_d, we, hit, arm_ok;
  assign we       = state_q inside {LA_PRE, LA_WAIT, LA_POST};
  assign arm_ok   = arm_i && !abort_i && (state_q == LA_IDLE || state_q == LA_DONE);
  assign cnt_inc  = cnt_q + CNT_ONE;
  assign post_len = DEPTH_L - {1'b0, pretrig_q};
  // Oldest retained sample sits pretrig samples before the trigger; wraps naturally at ADDR_W bits.
  assign rd_phys  = trig_addr_q - pretrig_q + rd_addr_i;
`ifdef LA_EDGE_TRIG_EN
  logic [PROBE_W-1:0] prev_probe_q, prev_probe_d, edge_bits;
  logic first_q, first_d;
  assign edge_bits = trig_mask_i & trig_edge_i;
  // Edge bits need the level match now and the opposite value last cycle; the cycle right after arm has no valid history.
  assign hit = la_match(LA_MAX_W'(probe_i), LA_MAX_W'(trig_mask_i), LA_MAX_W'(trig_value_i))
            && la_match(LA_MAX_W'(prev_probe_q), LA_MAX_W'(edge_bits), LA_MAX_W'(~trig_value_i))
            && !(first_q && |edge_bits);
  always_comb begin
    prev_probe_d = probe_i;
    first_d      = arm_ok;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_probe_q <= '0;
      first_q      <= 1'b0;
    end else begin
      prev_probe_q <= prev_probe_d;
      first_q      <= first_d;
    end
  end
`else
  assign hit = la_match(LA_MAX_W'(probe_i), LA_MAX_W'(trig_mask_i), LA_MAX_W'(trig_value_i));
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pretrig_d   = pretrig_q;
    trig_addr_d = trig_addr_q;
    wr_ptr_d    = we ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    case (state_q)
      // pretrig_i is ADDR_W wide, so it can never exceed DEPTH-1 and needs no explicit clamp.
      LA_IDLE, LA_DONE: if (arm_i) begin
        pretrig_d = pretrig_i;
        cnt_d     = '0;
        state_d   = (pretrig_i == '0) ? LA_WAIT : LA_PRE;
      end
      LA_PRE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == {1'b0, pretrig_q}) begin
          cnt_d   = '0;
          state_d = LA_WAIT;
        end
      end
      // The trigger sample is post sample #1; a one-sample post window completes right here.
      LA_WAIT: if (hit) begin
        trig_addr_d = wr_ptr_q;
        cnt_d       = CNT_ONE;
        state_d     = (post_len == CNT_ONE) ? LA_DONE : LA_POST;
      end
      LA_POST: begin
        cnt_d = cnt_inc;
        if (cnt_inc == post_len) state_d = LA_DONE;
      end
      default: state_d = LA_IDLE;
    endcase
    if (abort_i) state_d = LA_IDLE;
    done_d = state_d == LA_DONE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= LA_IDLE;
      cnt_q       <= '0;
      pretrig_q   <= '0;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pretrig_q   <= pretrig_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      done_q      <= done_d;
    end
  end
  la_sample_ram #(.PROBE_W(PROBE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .resetn    (resetn),
    .we_i      (we),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (probe_i),
    .rd_addr_i (rd_phys),
    .rd_data_o (rd_data_o)
  );
  assign state_o     = state_q;
  assign done_o      = done_q;
  assign trig_addr_o = trig_addr_q;
endmodule

// File: tb/tb_la_capture_core.sv
// tb_la_capture_core: self-checking bench for la_capture_core with DEPTH=16.
module tb_la_capture_core;
  localparam int W = 37;
  localparam int D = 16;
  localparam int AW = 4;
  logic clk = 1'b0, resetn = 1'b0, arm_i = 1'b0, abort_i = 1'b0;
  logic [W-1:0] probe_i = '0, trig_mask_i = '0, trig_value_i = '0;
  logic [AW-1:0] pretrig_i = '0, rd_addr_i = '0;
  logic [W-1:0] rd_data_o;
  logic [2:0] state_o;
  logic done_o;
  logic [AW-1:0] trig_addr_o;
`ifdef LA_EDGE_TRIG_EN
  logic [W-1:0] trig_edge_i = '0;
`endif
  int checks = 0, passed = 0;
  bit run_ctr = 1'b0;
  typedef struct {
    logic [AW-1:0] pre;
    logic [W-1:0]  mask;
    logic [W-1:0]  value;
    int            cyc;
    logic [AW-1:0] taddr;
    logic [W-1:0]  base;
  } vec_t;
  typedef struct {
    int           idx;
    logic [W-1:0] exp;
  } rd_t;
  vec_t vecs[4];
  rd_t sb[$];
  always #5 clk = ~clk;
  la_capture_core #(.PROBE_W(W), .DEPTH(D)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .probe_i      (probe_i),
    .arm_i        (arm_i),
    .abort_i      (abort_i),
    .trig_mask_i  (trig_mask_i),
    .trig_value_i (trig_value_i),
`ifdef LA_EDGE_TRIG_EN
    .trig_edge_i  (trig_edge_i),
`endif
    .pretrig_i    (pretrig_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .state_o      (state_o),
    .done_o       (done_o),
    .trig_addr_o  (trig_addr_o)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (run_ctr) probe_i = probe_i + W'(1);
  endtask
  task automatic do_reset();
    run_ctr = 1'b0;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    tick();
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 200) begin
      tick();
      n++;
    end
  endtask
  task automatic arm_capture(input logic [AW-1:0] pre, input logic [W-1:0] mask, input logic [W-1:0] value);
    trig_mask_i = mask;
    trig_value_i = value;
    pretrig_i = pre;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    rd_t r;
    vecs[0] = '{4'd4,  {W{1'b1}}, 37'd20, 31, 4'd3,  37'd16};
    vecs[1] = '{4'd0,  '0,        37'd5,  16, 4'd0,  37'd1};
    vecs[2] = '{4'd15, {W{1'b1}}, 37'd30, 30, 4'd13, 37'd15};
    vecs[3] = '{4'd8,  37'hF,     37'd5,  28, 4'd4,  37'd13};
    tick();
    tick();
    chk("reset_state", state_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_trig_addr", trig_addr_o, 0);
    chk("reset_rd_data", rd_data_o, 0);
    foreach (vecs[v]) begin
      do_reset();
      probe_i = '0;
      run_ctr = 1'b1;
      arm_capture(vecs[v].pre, vecs[v].mask, vecs[v].value);
      wait_done(n);
      run_ctr = 1'b0;
      chk($sformatf("v%0d_cycles", v), 64'(n), 64'(vecs[v].cyc));
      chk($sformatf("v%0d_state", v), state_o, 4);
      chk($sformatf("v%0d_trig_addr", v), trig_addr_o, vecs[v].taddr);
      for (int i = 0; i < D; i++) begin
        rd_addr_i = AW'(i);
        sb.push_back('{i, vecs[v].base + W'(i)});
        tick();
        r = sb.pop_front();
        chk($sformatf("v%0d_rd%0d", v, r.idx), rd_data_o, r.exp);
      end
    end
    do_reset();
    probe_i = '0;
    run_ctr = 1'b1;
    arm_capture(4'd2, {W{1'b1}}, {W{1'b1}});
    tick();
    tick();
    tick();
    chk("abort_in_wait", state_o, 2);
    pretrig_i = 4'd5;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    chk("arm_ignored_wait", state_o, 2);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_state", state_o, 0);
    chk("abort_done", done_o, 0);
    arm_capture(4'd0, '0, '0);
    wait_done(n);
    chk("rearm_after_abort_cycles", 64'(n), 16);
    chk("rearm_after_abort_state", state_o, 4);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_from_done", done_o, 0);
    abort_i = 1'b1;
    arm_i = 1'b1;
    tick();
    abort_i = 1'b0;
    arm_i = 1'b0;
    chk("arm_abort_same_cycle", state_o, 0);
    do_reset();
    probe_i = '0;
    run_ctr = 1'b1;
    arm_capture(4'd4, {W{1'b1}}, 37'd20);
    wait_done(n);
    chk("rearm_first_done", done_o, 1);
    arm_capture(4'd4, '0, '0);
    chk("rearm_done_cleared", done_o, 0);
    chk("rearm_state_pre", state_o, 1);
    n = 0;
    while (state_o !== 3'd3 && n < 50) begin
      tick();
      n++;
    end
    chk("reach_post", state_o, 3);
    chk("post_trig_addr", trig_addr_o, 3);
    resetn = 1'b0;
    #1;
    chk("async_reset_state", state_o, 0);
    chk("async_reset_done", done_o, 0);
    chk("async_reset_trig_addr", trig_addr_o, 0);
    #1;
    resetn = 1'b1;
    run_ctr = 1'b0;
`ifdef LA_EDGE_TRIG_EN
    do_reset();
    probe_i = 37'd1;
    trig_edge_i = 37'd1;
    arm_capture(4'd0, 37'd1, 37'd1);
    repeat (4) tick();
    chk("edge_held_high", state_o, 2);
    probe_i = '0;
    tick();
    chk("edge_fall", state_o, 2);
    probe_i = 37'd1;
    tick();
    chk("edge_rise", state_o, 3);
    chk("edge_trig_addr", trig_addr_o, 5);
    trig_edge_i = '0;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
